// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall/forwarding controller.
package pipe_hazard_pkg;

  typedef enum logic [0:0] {
    ST_RUN,
    ST_FPU_WAIT
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned RF_INT = 0;
  localparam int unsigned RF_FP  = 1;

endpackage

// File: rtl/pipe_hazard_match.sv
// One ID-source vs. producer comparator; integer x0 never matches since it is hard-wired.
module pipe_hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned RF_SEL_W   = 1
) (
  input  logic                  src_used,
  input  logic [RF_SEL_W-1:0]   src_rf,
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  prd_valid,
  input  logic                  prd_we,
  input  logic [RF_SEL_W-1:0]   prd_rf,
  input  logic [REG_ADDR_W-1:0] prd_addr,
  output logic                  hit
);

  logic is_x0;

  assign is_x0 = (src_rf == RF_SEL_W'(RF_INT)) && (src_addr == '0);
  assign hit   = src_used && prd_valid && prd_we && (src_rf == prd_rf) &&
                 (src_addr == prd_addr) && !is_x0;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, stall, forwarding and FPU-sequencing control for the five-stage pipeline.
// Define PIPE_HAZARD_FWD_EN to enable operand forwarding; otherwise every RAW match stalls.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned NUM_RF      = 2,
  parameter int unsigned RF_SEL_W    = (NUM_RF > 1) ? $clog2(NUM_RF) : 1,
  parameter int unsigned FPU_MAX_LAT = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [RF_SEL_W-1:0]   id_rs1_rf,
  input  logic [RF_SEL_W-1:0]   id_rs2_rf,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_valid,
  input  logic                  ex_rd_we,
  input  logic                  ex_is_load,
  input  logic                  ex_is_fpu_multi,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [RF_SEL_W-1:0]   ex_rd_rf,
  input  logic                  mem_valid,
  input  logic                  mem_rd_we,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [RF_SEL_W-1:0]   mem_rd_rf,
  input  logic                  wb_valid,
  input  logic                  wb_rd_we,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [RF_SEL_W-1:0]   wb_rd_rf,
  input  logic                  br_taken,
  input  logic                  fpu_stall,
  output logic                  fpu_start,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  fpu_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int unsigned TO_W = $clog2(FPU_MAX_LAT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FPU_MAX_LAT - 1);

  // Source index: 0 = rs1, 1 = rs2. Producer index: 0 = EX, 1 = MEM, 2 = WB.
  logic [1:0]                 s_used;
  logic [1:0][RF_SEL_W-1:0]   s_rf;
  logic [1:0][REG_ADDR_W-1:0] s_addr;
  logic [2:0]                 p_valid, p_we;
  logic [2:0][RF_SEL_W-1:0]   p_rf;
  logic [2:0][REG_ADDR_W-1:0] p_addr;
  logic [1:0][2:0]            hit;

  assign s_used  = {id_rs2_used, id_rs1_used};
  assign s_rf    = {id_rs2_rf, id_rs1_rf};
  assign s_addr  = {id_rs2_addr, id_rs1_addr};
  assign p_valid = {wb_valid, mem_valid, ex_valid};
  assign p_we    = {wb_rd_we, mem_rd_we, ex_rd_we};
  assign p_rf    = {wb_rd_rf, mem_rd_rf, ex_rd_rf};
  assign p_addr  = {wb_rd_addr, mem_rd_addr, ex_rd_addr};

  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar p = 0; p < 3; p++) begin : g_prd
      pipe_hazard_match #(
        .REG_ADDR_W(REG_ADDR_W),
        .RF_SEL_W  (RF_SEL_W)
      ) u_match (
        .src_used (s_used[s]),
        .src_rf   (s_rf[s]),
        .src_addr (s_addr[s]),
        .prd_valid(p_valid[p]),
        .prd_we   (p_we[p]),
        .prd_rf   (p_rf[p]),
        .prd_addr (p_addr[p]),
        .hit      (hit[s][p])
      );
    end
  end

  logic load_use, raw_stall;
  assign load_use = ex_is_load && (hit[0][0] || hit[1][0]);

`ifdef PIPE_HAZARD_FWD_EN
  assign raw_stall = load_use;
`else
  assign raw_stall = load_use || (|hit);
`endif

  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
`ifdef PIPE_HAZARD_FWD_EN
    if (!Rst) begin
      if (hit[0][1])      fwd_a_sel = FWD_MEM;
      else if (hit[0][2]) fwd_a_sel = FWD_WB;
      if (hit[1][1])      fwd_b_sel = FWD_MEM;
      else if (hit[1][2]) fwd_b_sel = FWD_WB;
    end
`endif
  end

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_set;
  logic            fpu_timeout_q;
  logic [CNT_W-1:0] stall_q;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    fpu_start    = 1'b0;
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    timeout_set  = 1'b0;
    if (Rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (state_q == ST_FPU_WAIT) begin
      if (fpu_stall && (to_cnt_q != TO_LAST)) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
        to_cnt_d     = to_cnt_q + TO_W'(1);
      end else begin
        // Normal completion or timeout: both release the pipeline this cycle.
        state_d     = ST_RUN;
        timeout_set = fpu_stall;
      end
    end else if (br_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_valid && ex_is_fpu_multi) begin
      fpu_start    = 1'b1;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
      state_d      = ST_FPU_WAIT;
      to_cnt_d     = '0;
    end else if (raw_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_RUN;
      to_cnt_q      <= '0;
      fpu_timeout_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      if (timeout_set) fpu_timeout_q <= 1'b1;
      if (!pc_en && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign fpu_timeout  = fpu_timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed self-checking bench for pipe_hazard_unit; expectations follow PIPE_HAZARD_FWD_EN.
module tb_pipe_hazard_unit;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned RF_SEL_W    = 1;
  localparam int unsigned FPU_MAX_LAT = 8;
  localparam int unsigned CNT_W       = 6;

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush,
  //  fpu_start}
  localparam logic [8:0] C_NORM  = 9'b11111_000_0;
  localparam logic [8:0] C_RST   = 9'b00000_111_0;
  localparam logic [8:0] C_STALL = 9'b00111_010_0;
  localparam logic [8:0] C_BR    = 9'b11111_110_0;
  localparam logic [8:0] C_FSTRT = 9'b00011_001_1;
  localparam logic [8:0] C_FHOLD = 9'b00011_001_0;

  logic                  Clk = 1'b0;
  logic                  Rst;
  logic [REG_ADDR_W-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic [RF_SEL_W-1:0]   id_rs1_rf, id_rs2_rf, ex_rd_rf, mem_rd_rf, wb_rd_rf;
  logic                  id_rs1_used, id_rs2_used;
  logic                  ex_valid, ex_rd_we, ex_is_load, ex_is_fpu_multi;
  logic                  mem_valid, mem_rd_we, wb_valid, wb_rd_we;
  logic                  br_taken, fpu_stall;
  logic                  fpu_start, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic                  if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]            fwd_a_sel, fwd_b_sel;
  logic                  fpu_timeout;
  logic [CNT_W-1:0]      stall_cycles;
  logic [8:0]            ctrl;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_RF     (2),
    .RF_SEL_W   (RF_SEL_W),
    .FPU_MAX_LAT(FPU_MAX_LAT),
    .CNT_W      (CNT_W)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rs1_rf      (id_rs1_rf),
    .id_rs2_rf      (id_rs2_rf),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .ex_valid       (ex_valid),
    .ex_rd_we       (ex_rd_we),
    .ex_is_load     (ex_is_load),
    .ex_is_fpu_multi(ex_is_fpu_multi),
    .ex_rd_addr     (ex_rd_addr),
    .ex_rd_rf       (ex_rd_rf),
    .mem_valid      (mem_valid),
    .mem_rd_we      (mem_rd_we),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_rf      (mem_rd_rf),
    .wb_valid       (wb_valid),
    .wb_rd_we       (wb_rd_we),
    .wb_rd_addr     (wb_rd_addr),
    .wb_rd_rf       (wb_rd_rf),
    .br_taken       (br_taken),
    .fpu_stall      (fpu_stall),
    .fpu_start      (fpu_start),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_flush   (ex_mem_flush),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .fpu_timeout    (fpu_timeout),
    .stall_cycles   (stall_cycles)
  );

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, fpu_start};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pc_en=0 cycles feed the stall-counter model.
  task automatic chk_ctrl(input string tag, input logic [8:0] exp);
    chk(tag, 32'(ctrl), 32'(exp));
    if (!exp[8]) exp_stall++;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic clear_inputs();
    {id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr} = '0;
    {id_rs1_rf, id_rs2_rf, ex_rd_rf, mem_rd_rf, wb_rd_rf} = '0;
    {id_rs1_used, id_rs2_used} = '0;
    {ex_valid, ex_rd_we, ex_is_load, ex_is_fpu_multi} = '0;
    {mem_valid, mem_rd_we, wb_valid, wb_rd_we, br_taken, fpu_stall} = '0;
  endtask

  task automatic set_src(input logic [4:0] a1, input logic r1, input logic u1,
                         input logic [4:0] a2, input logic r2, input logic u2);
    id_rs1_addr = a1; id_rs1_rf = r1; id_rs1_used = u1;
    id_rs2_addr = a2; id_rs2_rf = r2; id_rs2_used = u2;
  endtask

  task automatic start_fpu();
    clear_inputs();
    ex_valid = 1'b1; ex_rd_we = 1'b1; ex_is_fpu_multi = 1'b1; ex_rd_rf = 1'b1;
    ex_rd_addr = 5'd3; fpu_stall = 1'b1;
    #1 chk_ctrl("fpu_start", C_FSTRT);
  endtask

  initial begin
    Rst = 1'b1;
    clear_inputs();
    set_src(5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    mem_valid = 1'b1; mem_rd_we = 1'b1; mem_rd_addr = 5'd5; mem_rd_rf = 1'b1;
    @(negedge Clk);
    #1 chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
    chk("rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);

    next_cycle();
    Rst = 1'b0;
    clear_inputs();
    #1 chk_ctrl("idle_ctrl", C_NORM);
    chk("idle_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("idle_timeout", 32'(fpu_timeout), 32'd0);

    // ld x5 in EX, add x6,x5,x7 in ID
    next_cycle();
    set_src(5'd5, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
    ex_valid = 1'b1; ex_rd_we = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd5;
    #1 chk_ctrl("load_use", C_STALL);
    chk("load_use_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);

    // Load has reached WB while its consumer is being resolved
    next_cycle();
    ex_valid = 1'b0; ex_rd_we = 1'b0; ex_is_load = 1'b0;
    wb_valid = 1'b1; wb_rd_we = 1'b1; wb_rd_addr = 5'd5;
    #1 chk_ctrl("wb_ctrl", FWD ? C_NORM : C_STALL);
    chk("wb_fwd_a", 32'(fwd_a_sel), FWD ? 32'd2 : 32'd0);
    chk("stall_cnt_1", 32'(stall_cycles), 32'd1);

    // Non-load x5 producer walks EX -> MEM(+WB older x5) -> WB -> gone; consumer reads rs2
    next_cycle();
    clear_inputs();
    set_src(5'd6, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
    ex_valid = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd5;
    #1 chk_ctrl("ex_match", FWD ? C_NORM : C_STALL);
    chk("ex_match_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
    next_cycle();
    ex_valid = 1'b0;
    mem_valid = 1'b1; mem_rd_we = 1'b1; mem_rd_addr = 5'd5;
    wb_valid = 1'b1; wb_rd_we = 1'b1; wb_rd_addr = 5'd5;
    #1 chk_ctrl("mem_match", FWD ? C_NORM : C_STALL);
    chk("mem_fwd_b", 32'(fwd_b_sel), FWD ? 32'd1 : 32'd0);
    chk("mem_fwd_a", 32'(fwd_a_sel), 32'd0);
    next_cycle();
    mem_valid = 1'b0;
    #1 chk_ctrl("wb_match", FWD ? C_NORM : C_STALL);
    chk("wb_fwd_b", 32'(fwd_b_sel), FWD ? 32'd2 : 32'd0);
    next_cycle();
    wb_valid = 1'b0;
    #1 chk_ctrl("clear_match", C_NORM);
    chk("clear_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);

    // x0 never matches; f0 does
    next_cycle();
    clear_inputs();
    set_src(5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    mem_valid = 1'b1; mem_rd_we = 1'b1; mem_rd_addr = 5'd0; mem_rd_rf = 1'b0;
    #1 chk_ctrl("x0_ctrl", C_NORM);
    chk("x0_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
    next_cycle();
    id_rs1_rf = 1'b1; mem_rd_rf = 1'b1;
    #1 chk_ctrl("f0_ctrl", FWD ? C_NORM : C_STALL);
    chk("f0_fwd_a", 32'(fwd_a_sel), FWD ? 32'd1 : 32'd0);

    // Register-file mismatch and unused source must not match
    next_cycle();
    set_src(5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    mem_rd_addr = 5'd9; mem_rd_rf = 1'b1;
    #1 chk_ctrl("rf_unused_ctrl", C_NORM);
    chk("rf_unused_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);

    // Taken branch discards a concurrent load-use stall
    next_cycle();
    clear_inputs();
    set_src(5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    ex_valid = 1'b1; ex_rd_we = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd5;
    br_taken = 1'b1;
    #1 chk_ctrl("br_ctrl", C_BR);

    // fdiv with fpu_stall high five cycles (start + 4 wait) then released
    next_cycle();
    start_fpu();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1 chk_ctrl($sformatf("fpu_hold_%0d", i), C_FHOLD);
    end
    next_cycle();
    fpu_stall = 1'b0;
    #1 chk_ctrl("fpu_exit", C_NORM);
    next_cycle();
    clear_inputs();
    #1 chk_ctrl("fpu_after", C_NORM);
    chk("fpu_stall_cnt", 32'(stall_cycles), 32'(exp_stall));
    chk("fpu_no_timeout", 32'(fpu_timeout), 32'd0);

    // fpu_stall stuck high -> timeout on the FPU_MAX_LAT-th wait cycle
    next_cycle();
    start_fpu();
    for (int i = 0; i < FPU_MAX_LAT - 1; i++) begin
      next_cycle();
      #1 chk_ctrl($sformatf("to_hold_%0d", i), C_FHOLD);
    end
    next_cycle();
    #1 chk_ctrl("to_exit", C_NORM);
    chk("to_not_yet", 32'(fpu_timeout), 32'd0);
    next_cycle();
    clear_inputs();
    fpu_stall = 1'b1;
    #1 chk_ctrl("to_run", C_NORM);
    chk("to_sticky", 32'(fpu_timeout), 32'd1);
    chk("to_stall_cnt", 32'(stall_cycles), 32'(exp_stall));

    // Reset mid-FPU_WAIT
    next_cycle();
    start_fpu();
    next_cycle();
    #1 chk_ctrl("rst_wait_hold", C_FHOLD);
    next_cycle();
    Rst = 1'b1;
    #1 chk("rst_wait_ctrl", 32'(ctrl), 32'(C_RST));
    next_cycle();
    Rst = 1'b0;
    clear_inputs();
    exp_stall = 0;
    #1 chk_ctrl("rst_wait_run", C_NORM);
    chk("rst_wait_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_wait_to", 32'(fpu_timeout), 32'd0);

    // Counter saturation with a held load-use stall
    set_src(5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    ex_valid = 1'b1; ex_rd_we = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd5;
    for (int i = 0; i < 70; i++) next_cycle();
    #1 chk("stall_saturate", 32'(stall_cycles), 32'd63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard, stall and forwarding controller for the five-stage RV64IF pipeline. Drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. Resolves RAW hazards across NUM_RF register files, either by forwarding or by stalling. Sequences multi-cycle FP-unit operations through the FP unit's start/stall handshake, and squashes wrong-path instructions on a taken branch.

## Interface
- REG_ADDR_W, 5: register address width.
- NUM_RF, 2: number of register files; index 0 = integer (x0 hard-wired), index 1 = FP.
- RF_SEL_W, (NUM_RF>1)?$clog2(NUM_RF):1: register-file select width (derived).
- FPU_MAX_LAT, 32: FPU_WAIT timeout, in cycles.
- CNT_W, 32: stall performance-counter width.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous reset, active-high.
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  ID-stage source registers.
- id_rs1_rf, id_rs2_rf  in  RF_SEL_W  source register file.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- ex_valid, ex_rd_we, ex_is_load, ex_is_fpu_multi  in  1  EX-stage qualifiers.
- ex_rd_addr / ex_rd_rf  in  REG_ADDR_W / RF_SEL_W  EX-stage destination.
- mem_valid, mem_rd_we, mem_rd_addr, mem_rd_rf  in  1,1,REG_ADDR_W,RF_SEL_W  MEM-stage destination.
- wb_valid, wb_rd_we, wb_rd_addr, wb_rd_rf  in  1,1,REG_ADDR_W,RF_SEL_W  WB-stage destination.
- br_taken  in  1  branch/jump resolved taken in EX.
- fpu_stall  in  1  FP unit busy.
- fpu_start  out  1  one-cycle start pulse to the FP unit.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a bubble (all-zero control) instead of capturing.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 register file, 01 EX/MEM, 10 MEM/WB.
- fpu_timeout  out  1  sticky; set when FPU_WAIT times out.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.

## Operation
- A source "matches" a producer when all of the following hold:
  - the source is used;
  - the producer is valid with rd_we=1;
  - rf and addr are equal;
  - the pair is not (rf=0, addr=0).
- FSM states RUN and FPU_WAIT. Output priority: Rst > FPU_WAIT > br_taken > RAW stall > normal.
- RUN, normal: all enables 1, all flushes 0.
- RUN, ex_valid & ex_is_fpu_multi:
  - fpu_start=1;
  - pc_en, if_id_en, id_ex_en = 0; ex_mem_flush=1; mem_wb_en=1;
  - next state FPU_WAIT; timeout counter cleared.
- FPU_WAIT, fpu_stall=1: same hold/bubble pattern as above, fpu_start=0, counter increments.
- FPU_WAIT, fpu_stall=0: all enables 1, result captured into EX/MEM, next state RUN.
- FPU_WAIT timeout: when the counter reaches FPU_MAX_LAT-1 with fpu_stall still 1:
  - fpu_timeout is set;
  - the cycle is treated as the exit cycle;
  - next state RUN.
- br_taken (RUN): if_id_flush=1, id_ex_flush=1, pc_en=1. Any concurrent RAW stall is discarded.
- Load-use: ex_is_load matches an ID source → pc_en=0, if_id_en=0, id_ex_flush=1.
- Forwarding select: MEM match gives 01 and takes priority over WB match, which gives 10. Otherwise 00.
- stall_cycles increments on every cycle with pc_en=0 and holds at all-ones.

## Timing
- State, timeout counter, fpu_timeout and stall_cycles are registered. All other outputs are combinational (Mealy) from the current state and current inputs.
- FP-unit handshake: fpu_stall is sampled from the cycle after fpu_start. An FPU op occupies 1 + N cycles, where N is the number of cycles with fpu_stall high.
- Load-use costs exactly one bubble.
- Rst high forces, on the same cycle:
  - all enables 0;
  - if_id_flush, id_ex_flush, ex_mem_flush = 1;
  - fpu_start 0, fwd sels 00.
- Reset values on the next edge: state RUN, counters 0, fpu_timeout 0.
- Rst asserted mid-FPU_WAIT aborts the wait. The FP unit is reset by the same signal.

## Configuration
- PIPE_HAZARD_FWD_EN defined: forwarding as in Operation. Only load-use stalls.
- PIPE_HAZARD_FWD_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00;
  - any EX, MEM or WB match stalls (pc_en=0, if_id_en=0, id_ex_flush=1) until it clears.

## Structure
- pipe_hazard_pkg holds:
  - the state enum (ST_RUN, ST_FPU_WAIT);
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - RF_INT=0, RF_FP=1.
- Sub-module pipe_hazard_match: one source-vs-producer comparator, including the x0 exclusion. It is instantiated once per source/producer pair.

## Test plan
- ld x5 in EX, add x6,x5,x7 in ID → one cycle pc_en=0 and id_ex_flush=1. Next cycle fwd_a_sel=10 (FWD_EN defined).
- add x5 in MEM, sub using x5 as rs2 in EX position → fwd_b_sel=01. With the macro undefined: stall for 3 cycles, then fwd_b_sel=00.
- Writer of x0 in MEM, reader of x0 → no stall, fwd 00. Same test with f0 (rf=1) → forward 01.
- fdiv in EX, fpu_stall high 5 cycles:
  - fpu_start high exactly 1 cycle;
  - 6 frozen/exit cycles total;
  - stall_cycles +5.
- fpu_stall stuck high → fpu_timeout=1 after FPU_MAX_LAT cycles, FSM back in RUN.
- br_taken coincident with a load-use match → if_id_flush=1, id_ex_flush=1, pc_en=1. Rst pulse mid-FPU_WAIT → RUN, counters 0.
